sync_pulse_decoder: RTL and testbench

- Slave-side decoder for the inter-board IO pulse line: the master's sync pulse and the sweep-loop TTL marker.
- Synchronises the asynchronous pin and measures the width of each high pulse.
- Classifies each pulse as sync (short) or loop (long) and emits one-cycle strobes for the slave sweep accumulator and the loop/sample counting logic.
- Maintains a mirrored sync flag, event counters and sticky error flags for the register bank.

---
 rtl/sync_pulse_decoder.sv | 195 +++++++++++++++++++
 tb/tb_sync_pulse_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_decoder.sv
// sync_pulse_decoder: slave-side decoder for the inter-board IO pulse line.
// Synchronises the raw pin, measures each high pulse and classifies it as a
// sync pulse (short) or a sweep-loop marker (long). It emits one-cycle strobes,
// mirrors a sync flag, counts events and keeps sticky error flags.
// Optional: define SYNC_PULSE_DECODER_TIMESTAMP_EN to add the ts_rise output,
// which captures a free-running timestamp at the rise of each accepted sync.
`timescale 1ns/1ps
module sync_pulse_decoder #(
    parameter int W_BITS      = 8,
    parameter int SYNC_MIN    = 2,
    parameter int SYNC_MAX    = 6,
    parameter int LOOP_MIN    = 24,
    parameter int LOOP_MAX    = 48,
    parameter int STUCK_LIMIT = 200,
    parameter int HOLDOFF     = 16,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sync_i,
    input  logic                clr_cnt,
    input  logic                clr_err,
    output logic                sync_pulse,
    output logic                loop_pulse,
    output logic                sync_flag,
    output logic [CNT_BITS-1:0] sync_count,
    output logic [CNT_BITS-1:0] loop_count,
    output logic                err_bad_width,
    output logic                err_stuck,
    output logic                line_high
`ifdef SYNC_PULSE_DECODER_TIMESTAMP_EN
    ,
    output logic [31:0]         ts_rise
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [W_BITS-1:0] SYNC_MIN_W = W_BITS'(SYNC_MIN);
    localparam logic [W_BITS-1:0] SYNC_MAX_W = W_BITS'(SYNC_MAX);
    localparam logic [W_BITS-1:0] LOOP_MIN_W = W_BITS'(LOOP_MIN);
    localparam logic [W_BITS-1:0] LOOP_MAX_W = W_BITS'(LOOP_MAX);
    localparam logic [W_BITS-1:0] STUCK_W    = W_BITS'(STUCK_LIMIT);
    localparam logic [15:0]       HOLDOFF_W  = 16'(HOLDOFF);
    localparam bit                HOLD_EN    = (HOLDOFF > 0);

    logic              s1, s2, s2_d;
    logic [1:0]        vld;
    logic              armed;
    logic [1:0]        state;
    logic [W_BITS-1:0] w, w_inc;
    logic [15:0]       hcnt;
    logic              pend_sync, pend_loop;
    logic              rise, hi_entry, fall_eval, in_sync_win, in_loop_win;
    logic              stuck_evt, bad_evt, sync_acc, loop_acc;

    assign line_high = s2;

    // Synchroniser plus arming: after reset the line must be seen low (through
    // a primed synchroniser) before any rise counts, so a pulse already in
    // progress at reset release is never picked up half-way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            vld   <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= sync_i;
            s2    <= s1;
            s2_d  <= s2;
            vld   <= {vld[0], 1'b1};
            armed <= armed | (vld[1] & ~s2);
        end
    end

    // Edge detection, saturating width increment and pulse classification.
    always_comb begin
        rise        = s2 & ~s2_d;
        hi_entry    = rise & armed;
        w_inc       = (w == '1) ? w : w + 1'b1;
        fall_eval   = enable && (state == ST_HIGH) && !s2;
        in_sync_win = (w >= SYNC_MIN_W) && (w <= SYNC_MAX_W);
        in_loop_win = (w >= LOOP_MIN_W) && (w <= LOOP_MAX_W);
        stuck_evt   = enable && (state == ST_HIGH) && s2 && (w_inc == STUCK_W);
        bad_evt     = fall_eval && !in_sync_win && !in_loop_win;
        sync_acc    = pend_sync & enable;
        loop_acc    = pend_loop & enable;
    end

    // Pulse-width FSM; an accepted pulse is latched into pend_* and strobed
    // one edge later, so strobes land on the 3rd edge after the low sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            w         <= '0;
            hcnt      <= '0;
            pend_sync <= 1'b0;
            pend_loop <= 1'b0;
        end else begin
            pend_sync <= 1'b0;
            pend_loop <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                w     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (hi_entry) begin
                            state <= ST_HIGH;
                            w     <= W_BITS'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (s2) begin
                            w <= w_inc;
                            if (w_inc == STUCK_W) state <= ST_STUCK;
                        end else begin
                            pend_sync <= in_sync_win;
                            pend_loop <= in_loop_win;
                            hcnt      <= HOLDOFF_W;
                            if ((in_sync_win || in_loop_win) && HOLD_EN)
                                state <= ST_HOLD;
                            else
                                state <= ST_IDLE;
                        end
                    end
                    ST_STUCK: begin
                        if (!s2) state <= ST_IDLE;
                    end
                    ST_HOLD: begin
                        hcnt <= hcnt - 1'b1;
                        if (hcnt <= 16'd1) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Strobes, mirrored sync flag and wrapping event counters (clear wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pulse <= 1'b0;
            loop_pulse <= 1'b0;
            sync_flag  <= 1'b0;
            sync_count <= '0;
            loop_count <= '0;
        end else begin
            sync_pulse <= sync_acc;
            loop_pulse <= loop_acc;
            if (sync_acc) sync_flag <= ~sync_flag;
            if (clr_cnt)       sync_count <= '0;
            else if (sync_acc) sync_count <= sync_count + 1'b1;
            if (clr_cnt)       loop_count <= '0;
            else if (loop_acc) loop_count <= loop_count + 1'b1;
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_bad_width <= 1'b0;
            err_stuck     <= 1'b0;
        end else begin
            if (bad_evt)      err_bad_width <= 1'b1;
            else if (clr_err) err_bad_width <= 1'b0;
            if (stuck_evt)    err_stuck <= 1'b1;
            else if (clr_err) err_stuck <= 1'b0;
        end
    end

`ifdef SYNC_PULSE_DECODER_TIMESTAMP_EN
    logic [31:0] ts_cnt, ts_shadow;

    // Free-running timestamp; shadow captured at HIGH entry, published with sync_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt    <= '0;
            ts_shadow <= '0;
            ts_rise   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (enable && (state == ST_IDLE) && hi_entry) ts_shadow <= ts_cnt;
            if (sync_acc) ts_rise <= ts_shadow;
        end
    end
`endif

endmodule

// File: tb/tb_sync_pulse_decoder.sv
// Self-checking bench for sync_pulse_decoder: directed scenarios plus a
// randomized pulse stream checked against a width-window reference model.
`timescale 1ns/1ps
module tb_sync_pulse_decoder;

    localparam int CB  = 4;
    localparam int MOD = 16;

    logic          clk = 1'b0;
    logic          rst, enable, sync_i, clr_cnt, clr_err;
    logic          sync_pulse, loop_pulse, sync_flag;
    logic [CB-1:0] sync_count, loop_count;
    logic          err_bad_width, err_stuck, line_high;
`ifdef SYNC_PULSE_DECODER_TIMESTAMP_EN
    logic [31:0]   ts_rise;
`endif

    sync_pulse_decoder #(.CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sync_i(sync_i),
        .clr_cnt(clr_cnt), .clr_err(clr_err),
        .sync_pulse(sync_pulse), .loop_pulse(loop_pulse), .sync_flag(sync_flag),
        .sync_count(sync_count), .loop_count(loop_count),
        .err_bad_width(err_bad_width), .err_stuck(err_stuck), .line_high(line_high)
`ifdef SYNC_PULSE_DECODER_TIMESTAMP_EN
        , .ts_rise(ts_rise)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ns, nl, ks, kl;
    int   exp_sc, exp_lc;
    logic exp_flag, exp_bad, exp_stuck;

    // Width windows straight from the decoder's contract: 1=sync, 2=loop, 0=bad.
    function automatic int classify(input int n);
        if (n >= 2 && n <= 6) return 1;
        if (n >= 24 && n <= 48) return 2;
        return 0;
    endfunction

    task automatic apply_model(input int cls);
        if (cls == 1) begin
            exp_sc   = (exp_sc + 1) % MOD;
            exp_flag = ~exp_flag;
        end else if (cls == 2) begin
            exp_lc = (exp_lc + 1) % MOD;
        end else begin
            exp_bad = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_sc = 0; exp_lc = 0; exp_flag = 1'b0; exp_bad = 1'b0; exp_stuck = 1'b0;
    endtask

    // One clock, sample #1 after the edge, accumulate strobes seen at index k.
    task automatic tick(input int k);
        @(posedge clk); #1;
        if (sync_pulse) begin ns++; ks = k; end
        if (loop_pulse) begin nl++; kl = k; end
    endtask

    // Drive a pulse sampled high on n edges, then watch win edges after the fall;
    // clr_cnt/clr_err are asserted only for edge index cc_k/ce_k of that window.
    task automatic drive_pulse(input int n, input int win, input int cc_k, input int ce_k);
        ns = 0; nl = 0; ks = -1; kl = -1;
        sync_i = 1'b1;
        for (int i = 0; i < n; i++) tick(0);
        sync_i = 1'b0;
        for (int k = 1; k <= win; k++) begin
            clr_cnt = (k == cc_k);
            clr_err = (k == ce_k);
            tick(k);
        end
        clr_cnt = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sync_i = 1'b0; clr_cnt = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({sync_pulse, loop_pulse, sync_flag, sync_count, loop_count,
             err_bad_width, err_stuck, line_high} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sc=%0d lc=%0d flag=%b eb=%b es=%b sp=%b lp=%b lh=%b required all 0",
                     sync_count, loop_count, sync_flag, err_bad_width, err_stuck, sync_pulse, loop_pulse, line_high);
        end
        rst = 1'b0;
        enable = 1'b1;
        model_reset();
        repeat (4) tick(0);
    endtask

    task automatic test_sync_basic();
        drive_pulse(3, 24, 0, 0);
        apply_model(classify(3));
        n_checks++;
        if (ns !== 1 || ks !== 4 || nl !== 0) begin
            n_fail++; $display("FAIL sync_strobe: got ns=%0d at k=%0d nl=%0d required ns=1 at k=4 nl=0", ns, ks, nl);
        end
        n_checks++;
        if (sync_count !== CB'(exp_sc) || sync_flag !== exp_flag) begin
            n_fail++; $display("FAIL sync_count_flag: got %0d/%b required %0d/%b", sync_count, sync_flag, exp_sc, exp_flag);
        end
        n_checks++;
        if (err_bad_width !== 1'b0 || err_stuck !== 1'b0) begin
            n_fail++; $display("FAIL sync_no_err: got eb=%b es=%b required 0/0", err_bad_width, err_stuck);
        end
    endtask

    task automatic test_loop();
        drive_pulse(33, 24, 0, 0);
        apply_model(classify(33));
        n_checks++;
        if (nl !== 1 || kl !== 4 || ns !== 0) begin
            n_fail++; $display("FAIL loop_strobe: got nl=%0d at k=%0d ns=%0d required nl=1 at k=4 ns=0", nl, kl, ns);
        end
        n_checks++;
        if (loop_count !== CB'(exp_lc) || sync_flag !== exp_flag || sync_count !== CB'(exp_sc)) begin
            n_fail++; $display("FAIL loop_count: got lc=%0d flag=%b sc=%0d required lc=%0d flag=%b sc=%0d",
                               loop_count, sync_flag, sync_count, exp_lc, exp_flag, exp_sc);
        end
    endtask

    task automatic test_bad_width();
        drive_pulse(1, 24, 0, 0);
        apply_model(classify(1));
        n_checks++;
        if (ns + nl !== 0 || err_bad_width !== exp_bad) begin
            n_fail++; $display("FAIL glitch_width: got strobes=%0d eb=%b required 0/%b", ns + nl, err_bad_width, exp_bad);
        end
        clr_err = 1'b1; tick(0); clr_err = 1'b0; exp_bad = 1'b0;
        drive_pulse(12, 24, 0, 0);
        apply_model(classify(12));
        n_checks++;
        if (ns + nl !== 0 || err_bad_width !== exp_bad) begin
            n_fail++; $display("FAIL mid_width: got strobes=%0d eb=%b required 0/%b", ns + nl, err_bad_width, exp_bad);
        end
        clr_err = 1'b1; tick(0); clr_err = 1'b0; exp_bad = 1'b0;
        n_checks++;
        if (err_bad_width !== 1'b0) begin
            n_fail++; $display("FAIL clr_err: got eb=%b required 0", err_bad_width);
        end
        // clear coincides with the classification edge of a glitch: the set must win
        drive_pulse(1, 24, 0, 3);
        apply_model(classify(1));
        n_checks++;
        if (err_bad_width !== 1'b1) begin
            n_fail++; $display("FAIL set_beats_clear: got eb=%b required 1", err_bad_width);
        end
        clr_err = 1'b1; tick(0); clr_err = 1'b0; exp_bad = 1'b0;
    endtask

    task automatic test_stuck();
        ns = 0; nl = 0;
        sync_i = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick(0);
            if (i == 200) begin
                n_checks++;
                if (err_stuck !== 1'b0 || line_high !== 1'b1) begin
                    n_fail++; $display("FAIL stuck_early: got es=%b lh=%b required 0/1", err_stuck, line_high);
                end
            end
            if (i == 203) begin
                n_checks++;
                if (err_stuck !== 1'b1) begin
                    n_fail++; $display("FAIL stuck_set: got es=%b required 1", err_stuck);
                end
            end
        end
        sync_i = 1'b0;
        for (int k = 1; k <= 24; k++) tick(k);
        exp_stuck = 1'b1;
        n_checks++;
        if (ns + nl !== 0 || err_bad_width !== exp_bad || err_stuck !== exp_stuck) begin
            n_fail++; $display("FAIL stuck_no_strobe: got strobes=%0d eb=%b es=%b required 0/%b/1",
                               ns + nl, err_bad_width, err_stuck, exp_bad);
        end
        drive_pulse(3, 24, 0, 0);
        apply_model(classify(3));
        n_checks++;
        if (ns !== 1 || sync_count !== CB'(exp_sc)) begin
            n_fail++; $display("FAIL after_stuck: got ns=%0d sc=%0d required 1/%0d", ns, sync_count, exp_sc);
        end
        clr_err = 1'b1; tick(0); clr_err = 1'b0; exp_stuck = 1'b0;
        n_checks++;
        if (err_stuck !== 1'b0) begin
            n_fail++; $display("FAIL stuck_clear: got es=%b required 0", err_stuck);
        end
    endtask

    task automatic test_holdoff();
        drive_pulse(3, 5, 0, 0);
        apply_model(1);
        drive_pulse(3, 24, 0, 0);
        n_checks++;
        if (ns + nl !== 0 || sync_count !== CB'(exp_sc) || err_bad_width !== exp_bad) begin
            n_fail++; $display("FAIL holdoff_ignore: got strobes=%0d sc=%0d eb=%b required 0/%0d/%b",
                               ns + nl, sync_count, err_bad_width, exp_sc, exp_bad);
        end
        drive_pulse(3, 30, 0, 0);
        apply_model(1);
        drive_pulse(3, 24, 0, 0);
        apply_model(1);
        n_checks++;
        if (ns !== 1 || sync_count !== CB'(exp_sc)) begin
            n_fail++; $display("FAIL holdoff_gap30: got ns=%0d sc=%0d required 1/%0d", ns, sync_count, exp_sc);
        end
    endtask

    task automatic test_enable();
        ns = 0; nl = 0;
        sync_i = 1'b1;
        repeat (10) tick(0);
        enable = 1'b0;
        repeat (5) tick(0);
        enable = 1'b1;
        repeat (18) tick(0);
        sync_i = 1'b0;
        for (int k = 1; k <= 24; k++) tick(k);
        n_checks++;
        if (ns + nl !== 0 || err_bad_width !== exp_bad || sync_count !== CB'(exp_sc) || loop_count !== CB'(exp_lc)) begin
            n_fail++; $display("FAIL enable_drop: got strobes=%0d eb=%b sc=%0d lc=%0d required 0/%b/%0d/%0d",
                               ns + nl, err_bad_width, sync_count, loop_count, exp_bad, exp_sc, exp_lc);
        end
        drive_pulse(3, 24, 0, 0);
        apply_model(1);
        n_checks++;
        if (ns !== 1 || sync_count !== CB'(exp_sc)) begin
            n_fail++; $display("FAIL after_enable: got ns=%0d sc=%0d required 1/%0d", ns, sync_count, exp_sc);
        end
    endtask

    task automatic test_rst_mid();
        ns = 0; nl = 0;
        sync_i = 1'b1;
        repeat (10) tick(0);
        rst = 1'b1;
        #2;
        n_checks++;
        if ({sync_pulse, loop_pulse, sync_flag, sync_count, loop_count, err_bad_width, err_stuck, line_high} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got sc=%0d lc=%0d flag=%b lh=%b required all 0",
                               sync_count, loop_count, sync_flag, line_high);
        end
        repeat (2) tick(0);
        rst = 1'b0;
        model_reset();
        ns = 0; nl = 0;
        repeat (10) tick(0);
        sync_i = 1'b0;
        for (int k = 1; k <= 24; k++) tick(k);
        n_checks++;
        if (ns + nl !== 0 || err_bad_width !== 1'b0 || sync_count !== CB'(0)) begin
            n_fail++; $display("FAIL rst_mid_pulse: got strobes=%0d eb=%b sc=%0d required 0/0/0",
                               ns + nl, err_bad_width, sync_count);
        end
        drive_pulse(3, 24, 0, 0);
        apply_model(1);
        n_checks++;
        if (ns !== 1 || sync_count !== CB'(exp_sc) || sync_flag !== exp_flag) begin
            n_fail++; $display("FAIL after_rst: got ns=%0d sc=%0d flag=%b required 1/%0d/%b",
                               ns, sync_count, sync_flag, exp_sc, exp_flag);
        end
    endtask

    task automatic test_clr_cnt();
        drive_pulse(33, 24, 0, 0);
        apply_model(2);
        // clr_cnt lands on the same edge as the sync increment: clear wins
        drive_pulse(3, 24, 4, 0);
        exp_flag = ~exp_flag;
        exp_sc = 0;
        exp_lc = 0;
        n_checks++;
        if (ns !== 1 || sync_count !== CB'(0) || loop_count !== CB'(0) || sync_flag !== exp_flag) begin
            n_fail++; $display("FAIL clr_cnt_wins: got ns=%0d sc=%0d lc=%0d flag=%b required 1/0/0/%b",
                               ns, sync_count, loop_count, sync_flag, exp_flag);
        end
    endtask

    task automatic test_random();
        int n, cls, exp_ns, exp_nl;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       n = int'($urandom_range(2, 6));
                1:       n = int'($urandom_range(24, 48));
                default: n = int'($urandom_range(1, 60));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                clr_err = 1'b1; tick(0); clr_err = 1'b0; exp_bad = 1'b0;
            end
            repeat ($urandom_range(0, 4)) tick(0);
            drive_pulse(n, 24, 0, 0);
            cls = classify(n);
            apply_model(cls);
            exp_ns = (cls == 1) ? 1 : 0;
            exp_nl = (cls == 2) ? 1 : 0;
            n_checks++;
            if (ns !== exp_ns || nl !== exp_nl || (exp_ns == 1 && ks !== 4) || (exp_nl == 1 && kl !== 4)) begin
                n_fail++; $display("FAIL rand_strobe w=%0d: got ns=%0d@%0d nl=%0d@%0d required ns=%0d nl=%0d at k=4",
                                   n, ns, ks, nl, kl, exp_ns, exp_nl);
            end
            n_checks++;
            if (sync_count !== CB'(exp_sc) || loop_count !== CB'(exp_lc) || sync_flag !== exp_flag) begin
                n_fail++; $display("FAIL rand_counts w=%0d: got sc=%0d lc=%0d flag=%b required %0d/%0d/%b",
                                   n, sync_count, loop_count, sync_flag, exp_sc, exp_lc, exp_flag);
            end
            n_checks++;
            if (err_bad_width !== exp_bad || err_stuck !== exp_stuck) begin
                n_fail++; $display("FAIL rand_err w=%0d: got eb=%b es=%b required %b/%b",
                                   n, err_bad_width, err_stuck, exp_bad, exp_stuck);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_basic();
        test_loop();
        test_bad_width();
        test_stuck();
        test_holdoff();
        test_enable();
        test_rst_mid();
        test_clr_cnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
